// File: rtl/ofm_wb_pkg.sv
// ofm_wb_pkg: shared constants, FSM encoding and tiling helpers for the OFM write-back path
package ofm_wb_pkg;
   localparam int DEF_SYSTOLIC_SIZE = 16;
   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_P             = 52;
   localparam int DEF_NO_FILTER     = 64;
   localparam int LANE_W            = 2 * DEF_DATA_WIDTH;
   localparam int OFM_WORDS         = DEF_P * DEF_P * DEF_NO_FILTER;
   localparam int NT                = (DEF_P + DEF_SYSTOLIC_SIZE - 1) / DEF_SYSTOLIC_SIZE;
   localparam int LT                = DEF_P - (NT - 1) * DEF_SYSTOLIC_SIZE;

   typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

   // tiles per pooled line and valid lanes in the last tile of a line
   function automatic int ofm_nt(input int p, input int s);
      return (p + s - 1) / s;
   endfunction

   function automatic int ofm_lt(input int p, input int s);
      return p - (ofm_nt(p, s) - 1) * s;
   endfunction
endpackage

// File: rtl/ofm_lane_serializer.sv
// ofm_lane_serializer: captures one tile of lanes and shifts them out lane 0 first
//   clk, rst_n   clock / async active-low reset
//   i_load       capture i_data, restart lane index at 0
//   i_shift      advance to next lane
//   i_last_idx   index of the last lane to be emitted for this tile
//   o_lane0      current lane value
//   o_idx        current lane index
//   o_last       current lane is the last one to emit
module ofm_lane_serializer #(
   parameter int LANES = 16,
   parameter int LW    = 16,
   parameter int CW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic [LANES*LW-1:0]   i_data,
   input  logic [CW-1:0]         i_last_idx,
   output logic [LW-1:0]         o_lane0,
   output logic [CW-1:0]         o_idx,
   output logic                  o_last
);
   logic [LANES*LW-1:0] r_data;
   logic [CW-1:0]       r_idx;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_data <= '0;
         r_idx  <= '0;
      end else if (i_load) begin
         r_data <= i_data;
         r_idx  <= '0;
      end else if (i_shift) begin
         r_data <= r_data >> LW;
         r_idx  <= r_idx + 1'b1;
      end

   assign o_lane0 = r_data[LW-1:0];
   assign o_idx   = r_idx;
   assign o_last  = r_idx == i_last_idx;
endmodule

// File: rtl/ofm_writeback.sv
// ofm_writeback: serializes pooled tiles into the OFM RAM in filter/row/column order
//   clk, rst_n          clock / async active-low reset
//   start               arms a full layer write-back (ignored while busy)
//   in_valid/in_ready   tile handshake, in_ready only in WAIT
//   in_data             SYSTOLIC_SIZE lanes of 2*DATA_WIDTH bits, lane 0 in the LSBs
//   ofm_we/addr/wdata   RAM write port, one word per cycle
//   busy                WAIT or WRITE
//   done                one-cycle pulse after the final write
// Build option: OFM_WB_RELU_EN clamps negative lanes to 0 before writing.
module ofm_writeback
   import ofm_wb_pkg::*;
#(
   parameter int SYSTOLIC_SIZE    = 16,
   parameter int DATA_WIDTH       = 8,
   parameter int OFM_SIZE_POOLING = 52,
   parameter int NO_FILTER        = 64,
   parameter int ADDR_WIDTH       = 18
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] in_data,
   output logic                                ofm_we,
   output logic [ADDR_WIDTH-1:0]               ofm_addr,
   output logic [2*DATA_WIDTH-1:0]             ofm_wdata,
   output logic                                busy,
   output logic                                done
);
   localparam int LW    = 2 * DATA_WIDTH;
   localparam int P     = OFM_SIZE_POOLING;
   localparam int NTILE = ofm_nt(P, SYSTOLIC_SIZE);
   localparam int LTAIL = ofm_lt(P, SYSTOLIC_SIZE);
   localparam int CW    = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
   localparam int TW    = $clog2(NTILE + 1);
   localparam int RW    = $clog2(P + 1);
   localparam int FW    = $clog2(NO_FILTER + 1);

   state_t                r_state, w_next;
   logic [TW-1:0]         r_t;
   logic [RW-1:0]         r_r;
   logic [FW-1:0]         r_f;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LW-1:0]         w_lane0;
   logic [CW-1:0]         w_idx;
   logic                  w_last_lane, w_accept, w_tile_end, w_layer_end;
   logic                  w_last_t, w_last_r, w_last_f;

   assign w_last_t    = r_t == TW'(NTILE - 1);
   assign w_last_r    = r_r == RW'(P - 1);
   assign w_last_f    = r_f == FW'(NO_FILTER - 1);
   assign w_accept    = in_valid && r_state == WAIT;
   assign w_tile_end  = r_state == WRITE && w_last_lane;
   assign w_layer_end = w_tile_end && w_last_t && w_last_r && w_last_f;

   ofm_lane_serializer #(.LANES(SYSTOLIC_SIZE), .LW(LW), .CW(CW)) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_accept),
      .i_shift   (r_state == WRITE),
      .i_data    (in_data),
      .i_last_idx(w_last_t ? CW'(LTAIL - 1) : CW'(SYSTOLIC_SIZE - 1)),
      .o_lane0   (w_lane0),
      .o_idx     (w_idx),
      .o_last    (w_last_lane)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      ofm_we   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         IDLE:  w_next = start ? WAIT : IDLE;
         WAIT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            w_next   = in_valid ? WRITE : WAIT;
         end
         WRITE: begin
            ofm_we = 1'b1;
            busy   = 1'b1;
            w_next = w_layer_end ? DONE : (w_tile_end ? WAIT : WRITE);
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
      endcase
   end

   // running base: +SYSTOLIC_SIZE per full tile, +LTAIL on the last tile lands on the next row
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_t    <= '0;
         r_r    <= '0;
         r_f    <= '0;
         r_base <= '0;
      end else if (r_state == IDLE && start) begin
         r_t    <= '0;
         r_r    <= '0;
         r_f    <= '0;
         r_base <= '0;
      end else if (w_tile_end) begin
         r_base <= r_base + (w_last_t ? ADDR_WIDTH'(LTAIL) : ADDR_WIDTH'(SYSTOLIC_SIZE));
         r_t    <= w_last_t ? '0 : r_t + 1'b1;
         if (w_last_t) r_r <= w_last_r ? '0 : r_r + 1'b1;
         if (w_last_t && w_last_r) r_f <= w_last_f ? '0 : r_f + 1'b1;
      end

   assign ofm_addr = r_base + ADDR_WIDTH'(w_idx);
`ifdef OFM_WB_RELU_EN
   assign ofm_wdata = w_lane0[LW-1] ? '0 : w_lane0;
`else
   assign ofm_wdata = w_lane0;
`endif
endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback: scoreboard bench for ofm_writeback (P=52, two filters)
module tb_ofm_writeback;
   localparam int SS = 16, LW = 16, AW = 18, P = 52, NF = 2;
   localparam int WORDS = P * P * NF;

   logic               clk = 0, rst_n = 0, start = 0, in_valid = 0;
   logic [SS*LW-1:0]   in_data = '0;
   logic               in_ready, ofm_we, busy, done;
   logic [AW-1:0]      ofm_addr;
   logic [LW-1:0]      ofm_wdata;

   logic [AW+LW-1:0]   q[$];
   logic [LW-1:0]      ram  [WORDS];
   logic [LW-1:0]      gold [WORDS];
   int                 wcnt [WORDS];
   int n_chk = 0, n_err = 0, n_wr = 0, n_done = 0, cyc = 0, last_we = -1, done_cyc = -1;

   ofm_writeback #(.SYSTOLIC_SIZE(SS), .DATA_WIDTH(8), .OFM_SIZE_POOLING(P),
                   .NO_FILTER(NF), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .ofm_we(ofm_we), .ofm_addr(ofm_addr), .ofm_wdata(ofm_wdata),
      .busy(busy), .done(done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [LW-1:0] mdl(input logic [LW-1:0] v);
`ifdef OFM_WB_RELU_EN
      return v[LW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // monitor: every write must match the head of the expectation queue
   always @(negedge clk) begin
      if (ofm_we) begin
         n_chk++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write got addr=%0d data=%h exp none", ofm_addr, ofm_wdata);
         end else begin
            logic [AW+LW-1:0] e;
            e = q.pop_front();
            if ({ofm_addr, ofm_wdata} !== e) begin
               n_err++;
               $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                        ofm_addr, ofm_wdata, e[AW+LW-1:LW], e[LW-1:0]);
            end
         end
         if (ofm_addr < AW'(WORDS)) begin
            wcnt[ofm_addr] = wcnt[ofm_addr] + 1;
            ram[ofm_addr]  = ofm_wdata;
         end
         last_we = cyc;
         n_wr++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic send(input logic [SS*LW-1:0] d, input int base, input int nv);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", in_ready, 1);
      for (int i = 0; i < nv; i++) begin
         q.push_back({AW'(base + i), mdl(d[i*LW +: LW])});
         gold[base + i] = mdl(d[i*LW +: LW]);
      end
      in_data  = d;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      in_data  = {8{$urandom}};
   endtask

   function automatic logic [SS*LW-1:0] rnd_tile();
      logic [SS*LW-1:0] d;
      for (int i = 0; i < SS; i++) d[i*LW +: LW] = LW'($urandom);
      return d;
   endfunction

   initial begin
      #500000 $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [SS*LW-1:0] d;
      int lows, bad, w;
      for (int i = 0; i < WORDS; i++) wcnt[i] = 0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", ofm_we, 0);
      chk("rst_addr", ofm_addr, 0);
      chk("rst_wdata", ofm_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk) rst_n = 1;
      // valid while idle is ignored
      in_valid = 1;
      @(negedge clk);
      chk("idle_ready", in_ready, 0);
      in_valid = 0;
      @(negedge clk);
      chk("idle_no_we", ofm_we, 0);
      start = 1;
      @(negedge clk) start = 0;
      chk("start_busy", busy, 1);
      chk("start_ready", in_ready, 1);

      // lanes 1..16 to addr 0..15, in_ready low for 16 cycles
      for (int i = 0; i < SS; i++) d[i*LW +: LW] = LW'(i + 1);
      send(d, 0, 16);
      lows = 0;
      repeat (16) begin
         @(negedge clk);
         if (!in_ready) lows++;
      end
      chk("ready_low_cycles", lows, 16);
      @(negedge clk);
      chk("ready_back", in_ready, 1);
      send(rnd_tile(), 16, 16);
      send(rnd_tile(), 32, 16);
      // last tile of a row: only 4 lanes written
      for (int i = 0; i < SS; i++) d[i*LW +: LW] = 16'h7FFF;
      send(d, 48, 4);
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (ofm_we || !in_ready) bad++;
      end
      chk("wait_idle_cycles", bad, 0);
      // next row starts at 52; start during WRITE must not disturb the counters
      send(rnd_tile(), 52, 16);
      repeat (3) @(negedge clk);
      start = 1;
      @(negedge clk) start = 0;
      chk("busy_in_write", busy, 1);
      send(rnd_tile(), 68, 16);
      // reset while lane 7 is on the bus
      send(rnd_tile(), 84, 16);
      repeat (7) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("rst_mid_we", ofm_we, 0);
      chk("rst_mid_busy", busy, 0);
      q.delete();
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < WORDS; i++) wcnt[i] = 0;
      n_wr = 0;
      n_done = 0;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;

      // full layer
      for (int f = 0; f < NF; f++)
         for (int r = 0; r < P; r++)
            for (int t = 0; t < 4; t++) begin
               d = rnd_tile();
               if (f == 0 && r == 0 && t == 0) d[2*LW +: LW] = 16'hFFFB;
               send(d, f*P*P + r*P + t*SS, (t == 3) ? 4 : 16);
            end
      w = 0;
      while (n_done == 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      chk("done_count", n_done, 1);
      chk("done_latency", done_cyc, last_we + 1);
      chk("write_count", n_wr, WORDS);
      chk("queue_empty", q.size(), 0);
      chk("busy_after", busy, 0);
      bad = 0;
      for (int i = 0; i < WORDS; i++)
         if (wcnt[i] != 1 || ram[i] !== gold[i]) bad++;
      chk("ram_match", bad, 0);
`ifdef OFM_WB_RELU_EN
      chk("neg_lane", ram[2], 0);
`else
      chk("neg_lane", ram[2], 16'hFFFB);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
